clock_hour_min: RTL and testbench

//  Watch timekeeping stage downstream of the minute-pulse generator. Counts one-cycle
//  clk_min pulses into a BCD hour:minute value (00:00-23:59).

---
 rtl/clock_hour_min.sv | 204 ++++++++++++++++++++
 tb/tb_clock_hour_min.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clock_hour_min.sv
// Hour:minute BCD timekeeper with RUN/SET modes, hour/day carry pulses and a seconds-clear pulse.
// Optional 12-hour display with PM flag is enabled by defining HOUR12_EN.
module clock_hour_min #(
    parameter int unsigned INIT_HOUR = 0,
    parameter int unsigned INIT_MIN  = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_min,
    input  logic       set_mode,
    input  logic       btn_inc_min,
    input  logic       btn_inc_hour,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       pm,
    output logic       clk_hour,
    output logic       clk_day,
    output logic       sec_clear
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    localparam logic [7:0] INIT_MIN_BCD  = {4'(INIT_MIN / 32'd10), 4'(INIT_MIN % 32'd10)};
    localparam logic [7:0] INIT_HOUR_BCD = {4'(INIT_HOUR / 32'd10), 4'(INIT_HOUR % 32'd10)};

    // Minute 00-59 plus one, wrapping 59 -> 00.
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m[3:0] == 4'd9) begin
            if (m[7:4] == 4'd5) begin
                r = 8'h00;
            end else begin
                r = {m[7:4] + 4'd1, 4'd0};
            end
        end else begin
            r = {m[7:4], m[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Hour 00-23 plus one, wrapping 23 -> 00.
    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        logic [7:0] r;
        if (h == 8'h23) begin
            r = 8'h00;
        end else if (h[3:0] == 4'd9) begin
            r = {h[7:4] + 4'd1, 4'd0};
        end else begin
            r = {h[7:4], h[3:0] + 4'd1};
        end
        return r;
    endfunction

`ifdef HOUR12_EN
    // Internal 24-hour BCD to 12-hour display BCD (00 shows as 12).
    function automatic logic [7:0] hour_to12(input logic [7:0] h);
        logic [4:0] b;
        logic [4:0] b12;
        logic [7:0] r;
        b = (5'(h[7:4]) * 5'd10) + 5'(h[3:0]);
        if (b == 5'd0) begin
            b12 = 5'd12;
        end else if (b > 5'd12) begin
            b12 = b - 5'd12;
        end else begin
            b12 = b;
        end
        if (b12 >= 5'd10) begin
            r = {4'd1, 4'(b12 - 5'd10)};
        end else begin
            r = {4'd0, 4'(b12)};
        end
        return r;
    endfunction
`endif

    state_t     r_state;
    logic [7:0] r_min;
    logic [7:0] r_hour;
    logic [7:0] r_hour_disp;
    logic       r_pm;
    logic       r_clk_hour;
    logic       r_clk_day;
    logic       r_sec_clear;

    state_t     w_state_nxt;
    logic [7:0] w_min_nxt;
    logic [7:0] w_hour_nxt;
    logic [7:0] w_hour_src;
    logic [7:0] w_hour_disp;
    logic       w_pm;
    logic       w_clk_hour;
    logic       w_clk_day;
    logic       w_sec_clear;

    // Next-state and next-time decisions, driven by the registered mode, not set_mode.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_hour_nxt  = r_hour;
        w_clk_hour  = 1'b0;
        w_clk_day   = 1'b0;
        w_sec_clear = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (clk_min) begin
                    w_min_nxt = min_inc(r_min);
                    if (r_min == 8'h59) begin
                        w_hour_nxt = hour_inc(r_hour);
                        w_clk_hour = 1'b1;
                        if (r_hour == 8'h23) begin
                            w_clk_day = 1'b1;
                        end else begin
                            w_clk_day = 1'b0;
                        end
                    end else begin
                        w_hour_nxt = r_hour;
                    end
                end else begin
                    w_min_nxt = r_min;
                end
                if (set_mode) begin
                    w_state_nxt = ST_SET;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SET: begin
                // Minute and hour adjust independently; a minute wrap never carries here.
                if (btn_inc_min) begin
                    w_min_nxt = min_inc(r_min);
                end else begin
                    w_min_nxt = r_min;
                end
                if (btn_inc_hour) begin
                    w_hour_nxt = hour_inc(r_hour);
                end else begin
                    w_hour_nxt = r_hour;
                end
                if (!set_mode) begin
                    w_state_nxt = ST_RUN;
                    w_sec_clear = 1'b1;
                end else begin
                    w_state_nxt = ST_SET;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Display-side hour value, so the registered hour_bcd/pm track the next internal hour.
    always_comb begin
        if (!reset_n) begin
            w_hour_src = INIT_HOUR_BCD;
        end else begin
            w_hour_src = w_hour_nxt;
        end
`ifdef HOUR12_EN
        w_hour_disp = hour_to12(w_hour_src);
        w_pm        = (w_hour_src >= 8'h12);
`else
        w_hour_disp = w_hour_src;
        w_pm        = 1'b0;
`endif
    end

    // State, time and pulse registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_min       <= INIT_MIN_BCD;
            r_hour      <= INIT_HOUR_BCD;
            r_clk_hour  <= 1'b0;
            r_clk_day   <= 1'b0;
            r_sec_clear <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_min       <= w_min_nxt;
            r_hour      <= w_hour_nxt;
            r_clk_hour  <= w_clk_hour;
            r_clk_day   <= w_clk_day;
            r_sec_clear <= w_sec_clear;
        end
    end

    // Registered display hour and PM flag; reset value is folded into w_hour_src.
    always_ff @(posedge clk) begin
        r_hour_disp <= w_hour_disp;
        r_pm        <= w_pm;
    end

    assign min_bcd   = r_min;
    assign hour_bcd  = r_hour_disp;
    assign pm        = r_pm;
    assign clk_hour  = r_clk_hour;
    assign clk_day   = r_clk_day;
    assign sec_clear = r_sec_clear;

endmodule

// File: tb/tb_clock_hour_min.sv
// Bench for clock_hour_min: directed scenarios plus random stimulus against a minutes-of-day model.
module tb_clock_hour_min;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_min = 1'b0;
    logic       set_mode = 1'b0;
    logic       btn_inc_min = 1'b0;
    logic       btn_inc_hour = 1'b0;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic       pm;
    logic       clk_hour;
    logic       clk_day;
    logic       sec_clear;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: time as minutes since midnight, plus mode and last-cycle pulses.
    int m_tod = 0;
    bit m_set = 1'b0;
    bit m_hp  = 1'b0;
    bit m_dp  = 1'b0;
    bit m_sc  = 1'b0;
    int hp_cnt = 0;
    int dp_cnt = 0;

    clock_hour_min dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_min     (clk_min),
        .set_mode    (set_mode),
        .btn_inc_min (btn_inc_min),
        .btn_inc_hour(btn_inc_hour),
        .min_bcd     (min_bcd),
        .hour_bcd    (hour_bcd),
        .pm          (pm),
        .clk_hour    (clk_hour),
        .clk_day     (clk_day),
        .sec_clear   (sec_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] hdisp(input int h);
`ifdef HOUR12_EN
        int h12;
        h12 = (h % 12 == 0) ? 12 : (h % 12);
        return to_bcd(h12);
`else
        return to_bcd(h);
`endif
    endfunction

    function automatic logic exp_pm(input int h);
`ifdef HOUR12_EN
        return (h >= 12);
`else
        return (h < 0);
`endif
    endfunction

    task automatic step(input bit rn, input bit cm, input bit sm, input bit bm, input bit bh);
        int h;
        int m;
        reset_n      = rn;
        clk_min      = cm;
        set_mode     = sm;
        btn_inc_min  = bm;
        btn_inc_hour = bh;
        @(posedge clk);
        m_hp = 1'b0;
        m_dp = 1'b0;
        m_sc = 1'b0;
        if (!rn) begin
            m_tod = 0;
            m_set = 1'b0;
        end else if (!m_set) begin
            if (cm) begin
                m_tod = (m_tod + 1) % 1440;
                m_hp  = (m_tod % 60 == 0);
                m_dp  = (m_tod == 0);
            end
            m_set = sm;
        end else begin
            h = m_tod / 60;
            m = m_tod % 60;
            if (bm) m = (m + 1) % 60;
            if (bh) h = (h + 1) % 24;
            m_tod = h * 60 + m;
            if (!sm) begin
                m_set = 1'b0;
                m_sc  = 1'b1;
            end
        end
        @(negedge clk);
        h = m_tod / 60;
        m = m_tod % 60;
        chk("time", {hour_bcd, min_bcd}, {hdisp(h), to_bcd(m)});
        chk("flags", {12'h000, clk_hour, clk_day, sec_clear, pm},
            {12'h000, m_hp, m_dp, m_sc, exp_pm(h)});
        if (clk_hour === 1'b1) hp_cnt++;
        if (clk_day === 1'b1) dp_cnt++;
    endtask

    initial begin
        bit sm_r;
        // T1: reset defaults
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_time", {hour_bcd, min_bcd}, {hdisp(0), 8'h00});
        chk("t1_pulses", {13'h0000, clk_hour, clk_day, sec_clear}, 16'h0000);

        // T2: 60 minute pulses -> 01:00, one clk_hour
        hp_cnt = 0;
        dp_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t2_time", {hour_bcd, min_bcd}, {hdisp(1), 8'h00});
        chk("t2_hour_pulses", 16'(hp_cnt), 16'd1);
        chk("t2_day_pulses", 16'(dp_cnt), 16'd0);

        // T3: set to 23:59, leave SET, one minute -> 00:00 with both carries
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 59; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_set", {hour_bcd, min_bcd}, {hdisp(23), 8'h59});
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_sec_clear", {15'h0000, sec_clear}, 16'h0001);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_sec_clear_off", {15'h0000, sec_clear}, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_wrap", {hour_bcd, min_bcd}, {hdisp(0), 8'h00});
        chk("t3_carries", {14'h0000, clk_hour, clk_day}, 16'h0003);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_carries_off", {14'h0000, clk_hour, clk_day}, 16'h0000);

        // T4: SET-mode minute wrap without carry, dropped clk_min, dual button
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 59; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_min_wrap", {hour_bcd, min_bcd}, {hdisp(10), 8'h00});
        chk("t4_no_carry", {15'h0000, clk_hour}, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_clk_min_drop", {hour_bcd, min_bcd}, {hdisp(10), 8'h00});
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_both", {hour_bcd, min_bcd}, {hdisp(11), 8'h01});

        // T5: move to 12:34, run, reset together with clk_min
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 33; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_time", {hour_bcd, min_bcd}, {hdisp(12), 8'h34});
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_reset", {hour_bcd, min_bcd}, {hdisp(0), 8'h00});

        // Random phase
        sm_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) sm_r = ~sm_r;
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 1) == 0),
                 sm_r,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
